// File: rtl/siphash_msg_ctrl_pkg.sv
// rtl/siphash_msg_ctrl_pkg.sv - shared SipHash feeder widths and FSM state encoding
package siphash_msg_ctrl_pkg;

    localparam int LANE_W = 8;
    localparam int WORD_W = 64;
    localparam int LANES  = WORD_W / LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_FILL   = 3'd2,
        ST_COMP   = 3'd3,
        ST_WAIT_C = 3'd4,
        ST_PAD    = 3'd5,
        ST_FIN    = 3'd6,
        ST_WAIT_F = 3'd7
    } msg_state_e;

endpackage

// File: rtl/siphash_msg_ctrl_if.sv
// rtl/siphash_msg_ctrl_if.sv - byte stream and siphash_core command bus
interface siphash_msg_ctrl_if
    import siphash_msg_ctrl_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [LANE_W-1:0] in_data;
    logic              in_last;
    logic              core_initialize;
    logic              core_compress;
    logic              core_finalize;
    logic [WORD_W-1:0] core_mi;
    logic              core_ready;
    logic              core_word_valid;

    // Environment side: byte producer plus the core
    modport master (
        output in_valid, in_data, in_last, core_ready, core_word_valid,
        input  in_ready, core_initialize, core_compress, core_finalize, core_mi
    );

    // Message controller side
    modport slave (
        input  in_valid, in_data, in_last, core_ready, core_word_valid,
        output in_ready, core_initialize, core_compress, core_finalize, core_mi
    );

endinterface

// File: rtl/siphash_msg_ctrl_word_packer.sv
// rtl/siphash_msg_ctrl_word_packer.sv - little-endian byte-to-word packer with length pad
module siphash_word_packer
    import siphash_msg_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              ins_i,
    input  logic [LANE_W-1:0] ins_data_i,
    input  logic              pad_i,
    input  logic [LANE_W-1:0] pad_len_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o
);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Next buffer/index: clear wins over insert, insert over length pad
    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (clr_i) begin
            buf_d = '0;
            idx_d = '0;
        end else if (ins_i) begin
            buf_d[idx_q*LANE_W +: LANE_W] = ins_data_i;
            idx_d = idx_q + 1'b1;
        end else if (pad_i) begin
            buf_d[WORD_W-1 -: LANE_W] = pad_len_i;
        end
    end

    // Buffer and byte index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

    assign word_o = buf_q;
    // The byte being inserted right now completes the word
    assign full_o = ins_i && (idx_q == IDX_W'(LANES - 1));

endmodule

// File: rtl/siphash_msg_ctrl.sv
// rtl/siphash_msg_ctrl.sv - byte-stream feeder sequencing siphash_core commands
module siphash_msg_ctrl
    import siphash_msg_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              start_empty_i,
    siphash_msg_ctrl_if.slave bus,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  byte_count_o
);

    msg_state_e        state_q;
    logic              empty_q, last_q, final_q;
    logic              init_q, comp_q, fin_q, done_q;
    logic [WORD_W-1:0] mi_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, cmd_q, pk_clr, pk_pad, pk_full;
    logic [WORD_W-1:0] pk_word;

    assign accept = (state_q == ST_FILL) && bus.in_valid;
    // Any pulse still on the bus blocks a new command, so commands never abut
    assign cmd_q  = init_q | comp_q | fin_q;
    // While the compress pulse is visible the core has not yet dropped ready
    assign pk_clr = ((state_q == ST_IDLE) && start_i) ||
                    ((state_q == ST_WAIT_C) && bus.core_ready && !comp_q);
    assign pk_pad = (state_q == ST_PAD);

    siphash_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (pk_clr),
        .ins_i      (accept),
        .ins_data_i (bus.in_data),
        .pad_i      (pk_pad),
        .pad_len_i  (cnt_q[LANE_W-1:0]),
        .word_o     (pk_word),
        .full_o     (pk_full)
    );

    // Message FSM with registered command pulses and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            empty_q <= 1'b0;
            last_q  <= 1'b0;
            final_q <= 1'b0;
            init_q  <= 1'b0;
            comp_q  <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            mi_q    <= '0;
            cnt_q   <= '0;
        end else begin
            init_q <= 1'b0;
            comp_q <= 1'b0;
            fin_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start_i) begin
                    empty_q <= start_empty_i;
                    last_q  <= 1'b0;
                    final_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_INIT;
                end
                ST_INIT: if (bus.core_ready && !cmd_q) begin
                    init_q  <= 1'b1;
                    state_q <= empty_q ? ST_PAD : ST_FILL;
                end
                ST_FILL: if (accept) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.in_last) last_q <= 1'b1;
                    if (pk_full)          state_q <= ST_COMP;
                    else if (bus.in_last) state_q <= ST_PAD;
                end
                ST_COMP: if (bus.core_ready && !cmd_q) begin
                    comp_q  <= 1'b1;
                    mi_q    <= pk_word;
                    state_q <= ST_WAIT_C;
                end
                ST_WAIT_C: if (bus.core_ready && !comp_q) begin
                    if (final_q)     state_q <= ST_FIN;
                    else if (last_q) state_q <= ST_PAD;
                    else             state_q <= ST_FILL;
                end
                ST_PAD: begin
                    final_q <= 1'b1;
                    state_q <= ST_COMP;
                end
                ST_FIN: if (bus.core_ready && !cmd_q) begin
                    fin_q   <= 1'b1;
                    state_q <= ST_WAIT_F;
                end
                ST_WAIT_F: if (bus.core_word_valid) begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready        = (state_q == ST_FILL);
    assign bus.core_initialize = init_q;
    assign bus.core_compress   = comp_q;
    assign bus.core_finalize   = fin_q;
    assign bus.core_mi         = mi_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign done_o              = done_q;
    assign byte_count_o        = cnt_q;

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// tb/tb_siphash_msg_ctrl.sv - scoreboard bench for siphash_msg_ctrl with a SipHash-2-4 core model
module tb_siphash_msg_ctrl;
    import siphash_msg_ctrl_pkg::*;

    localparam int CNT_W = 16;
    localparam logic [63:0] K0 = 64'h0706050403020100;
    localparam logic [63:0] K1 = 64'h0f0e0d0c0b0a0908;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_i = 1'b0;
    logic start_empty_i = 1'b0;
    logic busy_o, done_o;
    logic [CNT_W-1:0] byte_count_o;
    logic hold_low = 1'b0;

    siphash_msg_ctrl_if bus();

    siphash_msg_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .start_empty_i(start_empty_i),
        .bus          (bus),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .byte_count_o (byte_count_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [255:0] sipround(input logic [255:0] s);
        logic [63:0] v0, v1, v2, v3;
        {v3, v2, v1, v0} = s;
        v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
        v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
        v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
        v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [255:0] sip_init();
        return {K1 ^ 64'h7465646279746573, K0 ^ 64'h6c7967656e657261,
                K1 ^ 64'h646f72616e646f6d, K0 ^ 64'h736f6d6570736575};
    endfunction

    function automatic logic [255:0] sip_compress(input logic [255:0] s, input logic [63:0] m);
        logic [255:0] t;
        t = s;
        t[255:192] = t[255:192] ^ m;
        t = sipround(sipround(t));
        t[63:0] = t[63:0] ^ m;
        return t;
    endfunction

    function automatic logic [63:0] sip_final(input logic [255:0] s);
        logic [255:0] t;
        t = s;
        t[191:128] = t[191:128] ^ 64'hff;
        for (int r = 0; r < 4; r++) t = sipround(t);
        return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
    endfunction

    logic [7:0] msg[$];

    function automatic logic [63:0] exp_word(input int w, input int n);
        logic [63:0] word;
        logic [31:0] nl;
        word = '0;
        nl = n;
        for (int b = 0; b < 8; b++)
            if (w * 8 + b < n) word[b*8 +: 8] = msg[w*8+b];
        if (w == n / 8) word[63:56] = nl[7:0];
        return word;
    endfunction

    function automatic logic [63:0] sip_ref(input int n);
        logic [255:0] s;
        s = sip_init();
        for (int w = 0; w <= n / 8; w++) s = sip_compress(s, exp_word(w, n));
        return sip_final(s);
    endfunction

    // Core model: ready drops the cycle after any command, returns after a latency
    logic [255:0] core_s;
    logic [63:0]  core_dig;
    logic         core_rdy, core_wv, fin_pend;
    int           core_lat;

    assign bus.core_ready      = core_rdy && !hold_low;
    assign bus.core_word_valid = core_wv;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_s <= '0; core_dig <= '0; core_rdy <= 1'b1; core_wv <= 1'b0;
            fin_pend <= 1'b0; core_lat <= 0;
        end else if (bus.core_initialize) begin
            core_s <= sip_init(); core_wv <= 1'b0; core_rdy <= 1'b0; core_lat <= 2;
        end else if (bus.core_compress) begin
            core_s <= sip_compress(core_s, bus.core_mi); core_rdy <= 1'b0; core_lat <= 3;
        end else if (bus.core_finalize) begin
            core_dig <= sip_final(core_s); core_rdy <= 1'b0; core_lat <= 5; fin_pend <= 1'b1;
        end else if (!core_rdy) begin
            if (core_lat == 0) begin
                core_rdy <= 1'b1;
                if (fin_pend) begin core_wv <= 1'b1; fin_pend <= 1'b0; end
            end else begin
                core_lat <= core_lat - 1;
            end
        end
    end

    // Monitor: scoreboard pop on compress, protocol counters
    logic [63:0] sb_q[$];
    int n_init = 0, n_comp = 0, n_fin = 0, n_done = 0, n_viol = 0, n_stall = 0;
    logic prev_cmd = 1'b0, comp_win = 1'b0;
    wire  cmd_now = bus.core_initialize | bus.core_compress | bus.core_finalize;

    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            prev_cmd <= 1'b0;
            comp_win <= 1'b0;
        end else begin
            if (bus.core_initialize) n_init <= n_init + 1;
            if (bus.core_finalize)   n_fin  <= n_fin + 1;
            if (done_o)              n_done <= n_done + 1;
            if (cmd_now && (!bus.core_ready || prev_cmd ||
                (32'(bus.core_initialize) + 32'(bus.core_compress) + 32'(bus.core_finalize) > 1)))
                n_viol <= n_viol + 1;
            prev_cmd <= cmd_now;
            if ((bus.core_compress || comp_win) && bus.in_ready) n_stall <= n_stall + 1;
            if (bus.core_compress) begin
                n_comp <= n_comp + 1;
                comp_win <= 1'b1;
                if (sb_q.size() == 0) chk("sb_unexpected_compress", bus.core_mi, 64'hx);
                else chk("core_mi", bus.core_mi, sb_q.pop_front());
            end else if (comp_win && bus.core_ready) begin
                comp_win <= 1'b0;
            end
        end
    end

    task automatic make_msg(input int n, input int kind);
        msg.delete();
        for (int i = 0; i < n; i++)
            msg.push_back(kind == 0 ? 8'(i) : kind == 1 ? 8'haa : 8'($urandom_range(0, 255)));
    endtask

    task automatic pulse_start(input logic empty);
        @(negedge clk); start_i = 1'b1; start_empty_i = empty;
        @(negedge clk); start_i = 1'b0; start_empty_i = 1'b0;
    endtask

    task automatic drive_bytes(input int cnt, input int total, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < cnt && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom_range(0, 255));
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = msg[i];
                bus.in_last  = (i == total - 1);
                if (bus.in_ready) i++;
            end
        end
        if (i < cnt) chk("drive_timeout", 64'(i), 64'(cnt));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int k = 0;
        while (n_done == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_done == base) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_msg(input int n, input bit gaps, input bit known, input logic [63:0] kdig);
        int b_init, b_comp, b_fin, b_done, b_viol, b_stall;
        b_init = n_init; b_comp = n_comp; b_fin = n_fin; b_done = n_done;
        b_viol = n_viol; b_stall = n_stall;
        for (int w = 0; w <= n / 8; w++) sb_q.push_back(exp_word(w, n));
        pulse_start(n == 0);
        if (n > 0) drive_bytes(n, n, gaps);
        wait_done(b_done, 20000);
        repeat (4) @(negedge clk);
        chk("n_init",   64'(n_init - b_init), 64'd1);
        chk("n_comp",   64'(n_comp - b_comp), 64'(n / 8 + 1));
        chk("n_fin",    64'(n_fin - b_fin),   64'd1);
        chk("n_done",   64'(n_done - b_done), 64'd1);
        chk("cmd_viol", 64'(n_viol - b_viol), 64'd0);
        chk("stall",    64'(n_stall - b_stall), 64'd0);
        chk("sb_left",  64'(sb_q.size()),     64'd0);
        chk("byte_cnt", 64'(byte_count_o),    64'(n % 65536));
        chk("busy_end", 64'(busy_o),          64'd0);
        chk("digest",   core_dig,             sip_ref(n));
        if (known) chk("digest_vec", core_dig, kdig);
    endtask

    initial begin
        int b_init, b_comp, b_done;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_cnt", 64'(byte_count_o), 64'd0);
        chk("rst_mi", bus.core_mi, 64'd0);
        chk("rst_init", 64'(bus.core_initialize), 64'd0);
        chk("rst_comp", 64'(bus.core_compress), 64'd0);
        chk("rst_fin", 64'(bus.core_finalize), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        make_msg(0, 0);   run_msg(0, 1'b0, 1'b1, 64'h726fdb47dd0e0e31);
        make_msg(15, 0);  run_msg(15, 1'b0, 1'b1, 64'ha129ca6149be45e5);
        make_msg(8, 0);   run_msg(8, 1'b0, 1'b0, 64'd0);
        chk("len_word8", bus.core_mi, 64'h0800000000000000);
        make_msg(300, 2); run_msg(300, 1'b1, 1'b0, 64'd0);
        chk("len_word300", 64'(bus.core_mi[63:56]), 64'h2c);

        // Abort in the middle of a compress, then a clean 7-byte message
        make_msg(16, 2);
        b_comp = n_comp;
        for (int w = 0; w <= 2; w++) sb_q.push_back(exp_word(w, 16));
        pulse_start(1'b0);
        drive_bytes(8, 16, 1'b0);
        for (int k = 0; k < 100 && n_comp == b_comp; k++) @(negedge clk);
        chk("mid_comp_seen", 64'(n_comp - b_comp), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_cnt", 64'(byte_count_o), 64'd0);
        chk("abort_cmd", 64'(cmd_now), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_pulse", 64'(cmd_now), 64'd0);
        make_msg(7, 1);   run_msg(7, 1'b0, 1'b0, 64'd0);
        chk("restart_mi", bus.core_mi, 64'h07aaaaaaaaaaaaaa);

        // Start while busy is ignored; initialize waits for core_ready
        make_msg(8, 2);
        b_init = n_init; b_comp = n_comp; b_done = n_done;
        sb_q.push_back(exp_word(0, 8));
        sb_q.push_back(exp_word(1, 8));
        hold_low = 1'b1;
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        chk("init_held", 64'(n_init - b_init), 64'd0);
        chk("busy_held", 64'(busy_o), 64'd1);
        pulse_start(1'b1);
        hold_low = 1'b0;
        drive_bytes(8, 8, 1'b0);
        pulse_start(1'b0);
        wait_done(b_done, 5000);
        repeat (4) @(negedge clk);
        chk("busy_init_once", 64'(n_init - b_init), 64'd1);
        chk("busy_comp", 64'(n_comp - b_comp), 64'd2);
        chk("busy_done_once", 64'(n_done - b_done), 64'd1);
        chk("busy_cnt", 64'(byte_count_o), 64'd8);
        chk("busy_idle", 64'(busy_o), 64'd0);
        chk("busy_digest", core_dig, sip_ref(8));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/siphash_msg_ctrl.md
Name: siphash_msg_ctrl

Overview:
- Upstream feeder for siphash_core.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 64-bit message words.
- Applies SipHash final-block padding: zero fill, with the length mod 256 placed in byte 7.
- Sequences the core's initialize/compress/finalize command pulses against core_ready, and signals completion when the core's digest word becomes valid.

Parameters:
- CNT_W, 16, width of the message byte counter. Wraps modulo 2^CNT_W; only bits [7:0] enter the padding.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- start  in  1  begin new message; sampled only in IDLE
- start_empty  in  1  qualifies start: the message is zero bytes long
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_data  in  8  message byte
- in_last  in  1  marks the final byte of the message
- core_initialize  out  1  one-cycle command pulse to the core
- core_compress  out  1  one-cycle command pulse to the core
- core_finalize  out  1  one-cycle command pulse to the core
- core_mi  out  64  message word; valid while core_compress=1
- core_ready  in  1  core idle/ready
- core_word_valid  in  1  core digest valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the digest is valid
- byte_count  out  CNT_W  bytes accepted for the current message

Behaviour:
- Interface decision: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - all outputs 0, core_mi = 0, byte_count = 0.
  - internal: state = IDLE, buffer = 0, byte index = 0, flags cleared.
- Reset mid-operation aborts the message immediately. No partial command pulse is emitted after reset deasserts.
- FSM states: IDLE, INIT, FILL, COMP, WAIT_C, PAD, FIN, WAIT_F.
- IDLE:
  - start=1 → clear buffer, byte index and byte_count, latch start_empty → INIT.
  - start while busy is ignored.
- INIT:
  - when core_ready=1, assert core_initialize for one cycle.
  - next state is PAD if the message is empty, otherwise FILL.
- FILL:
  - in_ready=1 only in this state.
  - accepted byte goes to buffer[8*idx+7 : 8*idx]; idx++ and byte_count++.
  - 8th byte, or a byte with in_last → set word_full/last flags as applicable, then go to COMP (word full) or PAD (last byte leaves fewer than 8).
- COMP:
  - when core_ready=1, drive core_mi = buffer and core_compress=1 for one cycle → WAIT_C.
  - commands are issued only while core_ready=1; never in two consecutive cycles.
- WAIT_C:
  - core_ready drops the cycle after compress; stay until core_ready=1.
  - then clear buffer and idx.
  - next state:
    - final word (padded) was compressed → FIN;
    - last byte filled a whole word → PAD (buffer is all zero);
    - otherwise → FILL.
- PAD: set buffer[63:56] = byte_count[7:0]; bytes idx..6 stay zero → COMP, with the final flag set.
- FIN: when core_ready=1, pulse core_finalize → WAIT_F.
- WAIT_F:
  - when core_word_valid=1, pulse done for one cycle → IDLE.
  - core_word_valid was cleared by the core on initialize, so a stale value cannot end the wait early.
- Timing:
  - one compress per 8 bytes.
  - the stream is stalled (in_ready=0) from COMP through WAIT_C; throughput is bound by the core's round count.
- Boundary cases:
  - a message of 8k bytes produces an extra length-only final word.
  - a message of 8k+7 bytes puts its length in byte 7 of the word holding its last 7 bytes.
  - byte_count wrap is harmless.
  - in_last with in_valid=0 is ignored.

Decomposition:
- Shared siphash package (include file): FSM state encodings, the byte-lane width constant (8) and the word width constant (64), reusable by siphash_core wrappers.
- One natural sub-module: siphash_word_packer. It holds the byte index, the 64-bit buffer, the insert/clear/pad-length controls and the full indication.

Test Plan:
- Empty message (start with start_empty=1) → one compress with core_mi = 0x0000000000000000, then finalize, then done. With key 0x0f..00 and 2-4 rounds, the digest is 0x726fdb47dd0e0e31.
- 15 bytes 0x00..0x0e → core_mi 0x0706050403020100, then 0x0f0e0d0c0b0a0908. Digest v0^v1^v2^v3 = 0xa129ca6149be45e5 for key 00..0f.
- 8 bytes 0x00..0x07 → core_mi 0x0706050403020100, then 0x0800000000000000; byte_count = 8.
- 300 random bytes with random in_valid gaps → 38 compresses; last word byte 7 = 0x2c; in_ready=0 throughout every COMP/WAIT_C; the digest matches the C model.
- Reset mid-compress, then start with a 7-byte 0xaa message → clean restart; single core_mi = 0x07aaaaaaaaaaaaaa; done pulses exactly once.
- start pulsed while busy, plus core_ready held low for 20 cycles in INIT → start ignored; core_initialize delayed until core_ready=1 and emitted exactly once.
